adc_snapshot_mc: RTL and testbench

- Multi-channel ADC snapshot capture engine in the RFDC data-clock domain.
- Selects one of N_CH parallel-sample ADC streams, waits for a trigger, then writes a fixed-length burst of consecutive valid words into the FPGA port of an AXI-lite BRAM (bram_din/bram_addr/bram_we). The PS reads the burst back over HPM.
- Configuration arrives as levels from an AXI-lite register block.
- Generalises the single-channel, free-running BRAM write path with these additions: channel select, trigger modes, programmable length, and a done/busy handshake.

---
 rtl/adc_snapshot_pkg.sv | 28 ++
 rtl/snap_thresh_cmp.sv | 31 +++
 rtl/adc_snapshot_mc.sv | 192 +++++++++++++++++++
 tb/tb_adc_snapshot_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_snapshot_pkg.sv
// rtl/adc_snapshot_pkg.sv - shared types and helpers for the ADC snapshot engine
//
// Purpose: FSM state encoding, trigger-mode codes and capture length
// normalisation shared by adc_snapshot_mc and future trigger variants.
package adc_snapshot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_THR = 2'd2;

  // A length of 0, or anything larger than the BRAM, means "fill the BRAM".
  function automatic logic [31:0] norm_len(input logic [31:0] len, input int unsigned aw);
    logic [31:0] full;
    full = 32'd1 << aw;
    if (len == 32'd0 || len > full) begin
      return full;
    end
    return len;
  endfunction

endpackage

// File: rtl/snap_thresh_cmp.sv
// rtl/snap_thresh_cmp.sv - N_PAR-lane signed >= threshold compare, OR-reduced
//
// Purpose: flags a parallel-sample word when any lane reaches the threshold.
// Ports:
//   word_i  N_PAR*DIN_WIDTH  parallel samples (lane order irrelevant here)
//   thr_i   DIN_WIDTH        signed threshold
//   hit_o   1                any lane >= thr_i (signed)
module snap_thresh_cmp
  import adc_snapshot_pkg::*;
#(
  parameter int N_PAR     = 8,
  parameter int DIN_WIDTH = 16
) (
  input  logic [N_PAR*DIN_WIDTH-1:0] word_i,
  input  logic signed [DIN_WIDTH-1:0] thr_i,
  output logic                        hit_o
);

  always_comb begin
    logic signed [DIN_WIDTH-1:0] lane;
    hit_o = 1'b0;
    lane  = '0;
    for (int i = 0; i < N_PAR; i++) begin
      lane = word_i[i*DIN_WIDTH +: DIN_WIDTH];
      if (lane >= thr_i) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_snapshot_mc.sv
// rtl/adc_snapshot_mc.sv - multi-channel ADC snapshot capture into BRAM
//
// Purpose: selects one ADC stream, waits for a trigger, then writes a burst of
// consecutive valid words to a BRAM write port, one cycle after each sample.
// Ports:
//   fpga_clk       capture clock (RFDC data clock)
//   rst            asynchronous active-high reset
//   din            N_CH streams, stream c at [c*N_PAR*DIN_WIDTH +: N_PAR*DIN_WIDTH]
//   din_valid      per-stream valid
//   ch_sel         stream select (clamped to N_CH-1), latched on arm
//   trig_mode      0 immediate, 1 ext_trig edge, 2 threshold, 3 as 0; latched on arm
//   ext_trig       external trigger level, synchronous to fpga_clk
//   threshold      signed threshold, latched on arm
//   capture_len    words to capture (0 or oversize = whole BRAM), latched on arm
//   arm            level; rising edge starts a capture from IDLE/DONE
//   bram_din/bram_addr/bram_we  registered BRAM write port
//   busy           high in ARMED or CAPTURE
//   done           high in DONE until the next arm
//   words_written  words written in the current or last capture
module adc_snapshot_mc
  import adc_snapshot_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int N_PAR           = 8,
  parameter int DIN_WIDTH       = 16,
  parameter int BRAM_ADDR_WIDTH = 10,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int SW             = N_PAR * DIN_WIDTH,
  localparam int LW             = BRAM_ADDR_WIDTH + 1
) (
  input  logic                        fpga_clk,
  input  logic                        rst,
  input  logic [N_CH*SW-1:0]          din,
  input  logic [N_CH-1:0]             din_valid,
  input  logic [CH_W-1:0]             ch_sel,
  input  logic [1:0]                  trig_mode,
  input  logic                        ext_trig,
  input  logic signed [DIN_WIDTH-1:0] threshold,
  input  logic [LW-1:0]               capture_len,
  input  logic                        arm,
  output logic [SW-1:0]               bram_din,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
  output logic                        bram_we,
  output logic                        busy,
  output logic                        done,
  output logic [LW-1:0]               words_written
);

  localparam logic [LW-1:0]              LEN_ONE  = LW'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

  state_e                       state_q;
  logic                         arm_dly_q, ext_dly_q;
  logic [CH_W-1:0]              ch_q;
  logic [1:0]                   mode_q;
  logic signed [DIN_WIDTH-1:0]  thr_q;
  logic [LW-1:0]                len_q;
  logic                         ext_seen_q;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [LW-1:0]                ww_q;
  logic                         we_q, busy_q, done_q;
  logic [SW-1:0]                din_q;
  logic [BRAM_ADDR_WIDTH-1:0]   baddr_q;

  logic                         arm_re, ext_re;
  logic [SW-1:0]                stream [N_CH];
  logic [SW-1:0]                w;
  logic                         v;
  logic                         thr_hit, trig_ok, cap, last;
  logic [CH_W-1:0]              ch_clamp;
  logic [LW-1:0]                len_norm;

  assign arm_re = arm & ~arm_dly_q;
  assign ext_re = ext_trig & ~ext_dly_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_stream
    assign stream[c] = din[c*SW +: SW];
  end

  assign w = stream[ch_q];
  assign v = din_valid[ch_q];

  always_comb begin
    ch_clamp = ch_sel;
    if (int'(ch_sel) >= N_CH) begin
      ch_clamp = CH_W'(N_CH - 1);
    end
  end

  assign len_norm = LW'(norm_len(32'(capture_len), BRAM_ADDR_WIDTH));

  snap_thresh_cmp #(
    .N_PAR     (N_PAR),
    .DIN_WIDTH (DIN_WIDTH)
  ) u_thresh (
    .word_i (w),
    .thr_i  (thr_q),
    .hit_o  (thr_hit)
  );

  // The ext edge may coincide with the first valid cycle, so it is ORed with
  // the sticky flag rather than waiting a cycle for the flag to register.
  always_comb begin
    case (mode_q)
      TRIG_EXT: trig_ok = ext_re | ext_seen_q;
      TRIG_THR: trig_ok = thr_hit;
      default:  trig_ok = 1'b1;
    endcase
  end

  assign cap  = v && ((state_q == ARMED && trig_ok) || state_q == CAPTURE);
  assign last = (ww_q + LEN_ONE) == len_q;

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      arm_dly_q  <= 1'b0;
      ext_dly_q  <= 1'b0;
      ch_q       <= '0;
      mode_q     <= '0;
      thr_q      <= '0;
      len_q      <= '0;
      ext_seen_q <= 1'b0;
      addr_q     <= '0;
      ww_q       <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      baddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      arm_dly_q <= arm;
      ext_dly_q <= ext_trig;
      we_q      <= 1'b0;

      // One-cycle write pipeline: the captured word, its address and the
      // running count all appear together on the cycle after the sample.
      if (cap) begin
        we_q    <= 1'b1;
        din_q   <= w;
        baddr_q <= addr_q;
        addr_q  <= addr_q + ADDR_ONE;
        ww_q    <= ww_q + LEN_ONE;
      end

      case (state_q)
        IDLE, DONE: begin
          if (arm_re) begin
            ch_q       <= ch_clamp;
            mode_q     <= trig_mode;
            thr_q      <= threshold;
            len_q      <= len_norm;
            ext_seen_q <= 1'b0;
            addr_q     <= '0;
            ww_q       <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ARMED;
          end
        end
        ARMED: begin
          if (ext_re) begin
            ext_seen_q <= 1'b1;
          end
          if (cap) begin
            state_q <= last ? DONE : CAPTURE;
            if (last) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (cap && last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_we       = we_q;
  assign bram_din      = din_q;
  assign bram_addr     = baddr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_adc_snapshot_mc.sv
// tb/tb_adc_snapshot_mc.sv - self-checking bench for adc_snapshot_mc
module tb_adc_snapshot_mc;

  localparam int N_CH = 4;
  localparam int N_PAR = 8;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SW = N_PAR * DW;

  logic                  fpga_clk = 1'b0;
  logic                  rst;
  logic [N_CH*SW-1:0]    din;
  logic [N_CH-1:0]       din_valid;
  logic [1:0]            ch_sel;
  logic [1:0]            trig_mode;
  logic                  ext_trig;
  logic signed [DW-1:0]  threshold;
  logic [AW:0]           capture_len;
  logic                  arm;
  logic [SW-1:0]         bram_din;
  logic [AW-1:0]         bram_addr;
  logic                  bram_we;
  logic                  busy;
  logic                  done;
  logic [AW:0]           words_written;

  adc_snapshot_mc #(
    .N_CH            (N_CH),
    .N_PAR           (N_PAR),
    .DIN_WIDTH       (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .fpga_clk      (fpga_clk),
    .rst           (rst),
    .din           (din),
    .din_valid     (din_valid),
    .ch_sel        (ch_sel),
    .trig_mode     (trig_mode),
    .ext_trig      (ext_trig),
    .threshold     (threshold),
    .capture_len   (capture_len),
    .arm           (arm),
    .bram_din      (bram_din),
    .bram_addr     (bram_addr),
    .bram_we       (bram_we),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 fpga_clk = ~fpga_clk;

  int cyc_n = 0;
  always @(posedge fpga_clk) cyc_n <= cyc_n + 1;

  logic [SW-1:0] sv [N_CH];
  always_comb din = {sv[3], sv[2], sv[1], sv[0]};

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] exp_addr;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  // Stream c, lane l carries c*4096 + k*8 + l; lane 0 sits in the MSBs.
  task automatic set_cnt(input int k);
    for (int c = 0; c < N_CH; c++)
      for (int l = 0; l < N_PAR; l++)
        sv[c][(N_PAR-1-l)*DW +: DW] = 16'(c*4096 + k*8 + l);
  endtask

  task automatic set_lane(input int c, input int l, input logic signed [DW-1:0] val);
    sv[c][(N_PAR-1-l)*DW +: DW] = val;
  endtask

  task automatic fill(input int c, input logic signed [DW-1:0] val);
    for (int l = 0; l < N_PAR; l++) set_lane(c, l, val);
  endtask

  // The word driven this cycle is sampled at the next edge and written then.
  task automatic push(input int c);
    q.push_back('{cyc: cyc_n + 1, addr: exp_addr, data: sv[c]});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_addr = '0;
  endtask

  always @(negedge fpga_clk) begin
    if (bram_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_we", SW'(bram_we), '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_cycle", SW'(cyc_n), SW'(e.cyc));
        chk("wr_addr", SW'(bram_addr), SW'(e.addr));
        chk("wr_data", bram_din, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    din_valid = '0;
    ch_sel = '0;
    trig_mode = '0;
    ext_trig = 1'b0;
    threshold = '0;
    capture_len = '0;
    arm = 1'b0;
    exp_addr = '0;
    set_cnt(0);
    tick();
    tick();

    chk("rst_we", SW'(bram_we), '0);
    chk("rst_busy", SW'(busy), '0);
    chk("rst_done", SW'(done), '0);
    chk("rst_ww", SW'(words_written), '0);
    chk("rst_addr", SW'(bram_addr), '0);
    chk("rst_din", bram_din, '0);
    rst = 1'b0;
    tick();

    // Immediate trigger, stream 2, 16 words.
    trig_mode = 2'd0; ch_sel = 2'd2; capture_len = 11'd16; din_valid = 4'hF;
    set_cnt(1);
    do_arm();
    chk("t1_busy", SW'(busy), SW'(1));
    for (int i = 0; i < 16; i++) begin
      set_cnt(10 + i);
      push(2);
      tick();
    end
    chk("t1_done", SW'(done), SW'(1));
    chk("t1_busy_end", SW'(busy), '0);
    chk("t1_ww", SW'(words_written), SW'(16));
    set_cnt(50);
    tick();
    chk("t1_q_empty", SW'(q.size()), '0);

    // Threshold trigger on stream 1; other streams sit above threshold.
    trig_mode = 2'd2; ch_sel = 2'd1; threshold = 16'sd1000; capture_len = 11'd4;
    fill(0, 16'sd20000); fill(2, 16'sd20000); fill(3, 16'sd20000); fill(1, 16'sd0);
    do_arm();
    for (int i = 0; i < 40; i++) begin
      fill(1, 16'(500 + i));
      set_lane(1, 0, -16'sd5);
      tick();
    end
    chk("t2_busy_wait", SW'(busy), SW'(1));
    chk("t2_ww_wait", SW'(words_written), '0);
    fill(1, 16'sd600);
    set_lane(1, 5, 16'sd1000);
    push(1);
    tick();
    for (int i = 0; i < 3; i++) begin
      fill(1, 16'(10 + i));
      push(1);
      tick();
    end
    chk("t2_done", SW'(done), SW'(1));
    chk("t2_ww", SW'(words_written), SW'(4));
    tick();
    chk("t2_q_empty", SW'(q.size()), '0);

    // Same with 999: no trigger, even after the threshold input changes.
    do_arm();
    threshold = -16'sd32768;
    for (int i = 0; i < 10; i++) begin
      fill(1, 16'sd500);
      set_lane(1, 0, -16'sd5);
      set_lane(1, 5, 16'sd999);
      tick();
    end
    chk("t2b_busy", SW'(busy), SW'(1));
    chk("t2b_done", SW'(done), '0);
    chk("t2b_ww", SW'(words_written), '0);
    set_lane(1, 5, 16'sd1000);
    push(1);
    tick();
    for (int i = 0; i < 3; i++) begin
      fill(1, 16'(20 + i));
      push(1);
      tick();
    end
    chk("t2b_done_end", SW'(done), SW'(1));
    tick();
    chk("t2b_q_empty", SW'(q.size()), '0);

    // External trigger pulses while stream 0 is invalid; sticky until valid.
    trig_mode = 2'd1; ch_sel = 2'd0; capture_len = 11'd3; din_valid = 4'b1110;
    set_cnt(200);
    do_arm();
    tick();
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    tick();
    tick();
    chk("t3_busy_pre", SW'(busy), SW'(1));
    chk("t3_ww_pre", SW'(words_written), '0);
    din_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      set_cnt(300 + i);
      push(0);
      tick();
    end
    chk("t3_done", SW'(done), SW'(1));
    chk("t3_ww", SW'(words_written), SW'(3));
    tick();
    chk("t3_q_empty", SW'(q.size()), '0);

    // capture_len 0 means whole BRAM; valid toggles every cycle.
    trig_mode = 2'd0; ch_sel = 2'd3; capture_len = 11'd0; din_valid = 4'h0;
    do_arm();
    for (int i = 0; i < 2048; i++) begin
      set_cnt(i);
      din_valid = (i % 2 == 0) ? 4'hF : 4'h0;
      if (i % 2 == 0) push(3);
      tick();
      if (i == 2046) begin
        chk("t4_last_addr", SW'(bram_addr), SW'(1023));
        chk("t4_done_at_last", SW'(done), SW'(1));
      end
    end
    chk("t4_ww", SW'(words_written), SW'(1024));
    chk("t4_busy", SW'(busy), '0);
    tick();
    chk("t4_q_empty", SW'(q.size()), '0);

    // Reset in the middle of a 16-word capture.
    ch_sel = 2'd1; capture_len = 11'd16; din_valid = 4'hF;
    do_arm();
    for (int i = 0; i < 7; i++) begin
      set_cnt(400 + i);
      push(1);
      tick();
    end
    @(negedge fpga_clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_we", SW'(bram_we), '0);
    chk("t5_rst_busy", SW'(busy), '0);
    chk("t5_rst_done", SW'(done), '0);
    chk("t5_rst_ww", SW'(words_written), '0);
    chk("t5_rst_addr", SW'(bram_addr), '0);
    chk("t5_rst_din", bram_din, '0);
    chk("t5_q_empty_rst", SW'(q.size()), '0);
    tick();
    rst = 1'b0;
    capture_len = 11'd2;
    do_arm();
    for (int i = 0; i < 2; i++) begin
      set_cnt(500 + i);
      push(1);
      tick();
    end
    chk("t5_done", SW'(done), SW'(1));
    chk("t5_ww", SW'(words_written), SW'(2));
    tick();
    chk("t5_q_empty", SW'(q.size()), '0);

    // arm re-edge during CAPTURE and config changes while busy are ignored;
    // arm held high across DONE does not restart.
    trig_mode = 2'd0; ch_sel = 2'd2; threshold = 16'sd1000; capture_len = 11'd6;
    set_cnt(600);
    arm = 1'b1;
    tick();
    exp_addr = '0;
    for (int i = 0; i < 6; i++) begin
      arm = (i == 2) ? 1'b0 : 1'b1;
      if (i == 3) begin
        ch_sel = 2'd0;
        threshold = -16'sd1;
        trig_mode = 2'd2;
        capture_len = 11'd1;
      end
      set_cnt(700 + i);
      push(2);
      tick();
    end
    chk("t6_done", SW'(done), SW'(1));
    chk("t6_busy", SW'(busy), '0);
    chk("t6_ww", SW'(words_written), SW'(6));
    for (int i = 0; i < 5; i++) begin
      set_cnt(800 + i);
      tick();
    end
    chk("t6_done_hold", SW'(done), SW'(1));
    chk("t6_ww_hold", SW'(words_written), SW'(6));
    chk("t6_q_empty", SW'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
